banked_mem_responder: RTL and testbench



---
 rtl/banked_mem_responder.sv | 95 +++++++++
 tb/tb_banked_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
// rtl/banked_mem_responder.sv - four-bank interleaved memory responder for cache line fills and writebacks
// Banks are selected by addr[2:1]; reads return exactly two cycles after acceptance.
module banked_mem_responder #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int IDX_W    = 8,
  parameter int BANK_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          stall,
  output logic [3:0]    busy,
  output logic          err
);

  localparam int DEPTH = 1 << IDX_W;

  logic             req;
  logic             accept;
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt [4];
  logic [DW-1:0]    mem [4][DEPTH];

  logic             s1_valid;
  logic [DW-1:0]    s1_data;
  logic             s2_valid;
  logic [DW-1:0]    s2_data;

  assign req  = wr | rd;
  assign bank = addr[2:1];
  assign idx  = addr[IDX_W+2:3];

  assign err    = (wr & rd) | (req & addr[0]);
  assign stall  = req & ~err & busy[bank];
  // Reset blocks acceptance so nothing issued during rst leaves a trace.
  assign accept = req & ~err & ~stall & ~rst;

  always_comb begin
    busy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (cnt[i] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt[i] <= 4'd0;
      end else if (accept && bank == 2'(i)) begin
        cnt[i] <= 4'(BANK_LAT - 1);
      end else if (cnt[i] != 4'd0) begin
        cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[bank][idx] <= data_in;
    end
  end

  // Two-stage return pipeline; data is zeroed whenever the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= accept & rd;
      s1_data  <= (accept && rd) ? mem[bank][idx] : '0;
      s2_valid <= s1_valid;
      s2_data  <= s1_valid ? s1_data : '0;
    end
  end

  assign data_valid = s2_valid;
  assign data_out   = s2_data;

  generate
    if (AW > IDX_W + 3) begin : g_alias_bits
      logic unused_hi;
      assign unused_hi = ^addr[AW-1:IDX_W+3];
    end
  endgenerate

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb/tb_banked_mem_responder.sv - scoreboard bench with directed and random traffic for banked_mem_responder
// Driver predicts err/stall/busy and queues expected reads; a negedge monitor retires returns.
module tb_banked_mem_responder;

  localparam int AW = 16, DW = 16, IDX_W = 8, BANK_LAT = 4;
  localparam int WORDS = 4 * (1 << IDX_W);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          wr, rd;
  logic [DW-1:0] data_out;
  logic          data_valid, stall, err;
  logic [3:0]    busy;

  banked_mem_responder #(.AW(AW), .DW(DW), .IDX_W(IDX_W), .BANK_LAT(BANK_LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mem_model [int];
  int          free_at [4];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          started = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Drives one cycle from posedge+1 and returns whether the model says it was accepted.
  task automatic step(input logic r, input logic w, input logic rr, input logic [15:0] a,
                      input logic [15:0] d, output logic acc);
    logic [3:0] eb;
    logic       ee, es, rq;
    int         b, key;
    exp_t       e;
    rst = r; wr = w; rd = rr; addr = a; data_in = d;
    b   = int'(a[2:1]);
    key = (int'(a) / 2) % WORDS;
    rq  = w | rr;
    for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
    ee  = (w & rr) | (rq & a[0]);
    es  = rq & !ee & eb[b];
    acc = rq & !ee & !es & !r;
    @(negedge clk);
    check("err", 32'(err), 32'(ee));
    check("stall", 32'(stall), 32'(es));
    check("busy", 32'(busy), 32'(eb));
    #1;
    if (acc) begin
      free_at[b] = cyc + BANK_LAT;
      if (w) mem_model[key] = d;
      else begin
        e.due   = cyc + 2;
        e.known = mem_model.exists(key);
        e.data  = e.known ? mem_model[key] : 16'h0;
        q.push_back(e);
      end
    end
    if (r) begin
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, acc);
  endtask

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (data_valid === 1'b1) begin
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid cycle %0d: got data_valid=1 data_out=0x%0h expected no return", cyc, data_out);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.due != cyc) begin
            miscompares++;
            $display("FAIL return_cycle: got cycle %0d expected cycle %0d", cyc, mon_e.due);
          end else if (mon_e.known && data_out !== mon_e.data) begin
            miscompares++;
            $display("FAIL read_data cycle %0d: got 0x%0h expected 0x%0h", cyc, data_out, mon_e.data);
          end
        end
      end else begin
        if (data_valid !== 1'b0 || data_out !== 16'h0) begin
          miscompares++;
          $display("FAIL idle_output cycle %0d: got valid=%b data=0x%0h expected valid=0 data=0", cyc, data_valid, data_out);
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
          miscompares++;
          $display("FAIL missing_return cycle %0d: got no data_valid expected 0x%0h", cyc, q[0].data);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          stalls, guard;
    logic [15:0] a, d;
    logic        w, r, rr;
    logic [15:0] pl1_data [4];
    pl1_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_data", 32'(data_out), 32'h0);
    started = 1'b1;

    // Line write across all banks, then line read back.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(2 * i), pl1_data[i], acc);
      check("line_write_accept", 32'(acc), 32'h1);
    end
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'h0100 + 16'(2 * i), 16'h0, acc);
    idle(4);

    // Same-bank read behind a write waits out the bank.
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'hABCD, acc);
    stalls = 0;
    guard  = 0;
    do begin
      step(1'b0, 1'b0, 1'b1, 16'h0018, 16'h0, acc);
      if (!acc) stalls++;
      guard++;
    end while (!acc && guard < 20);
    check("same_bank_stalls", 32'(stalls), 32'd3);
    idle(4);

    // Illegal requests.
    step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h7777, acc);
    step(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0, acc);
    idle(4);

    // Reset drops the in-flight read, keeps array contents.
    step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0, acc);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, acc);
    step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0, acc);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 16'h0102, 16'hDEAD, acc);
    step(1'b0, 1'b0, 1'b1, 16'h0102, 16'h0, acc);
    idle(4);

    // Index aliasing above the bank depth.
    step(1'b0, 1'b1, 1'b0, 16'h0006, 16'h5A5A, acc);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 16'h0806, 16'h0, acc);
    idle(4);

    // Random traffic over a small address window so aliases and conflicts recur.
    for (int n = 0; n < 600; n++) begin
      a  = 16'($urandom_range(0, 63));
      a[0] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) a[15:11] = 5'($urandom);
      d  = 16'($urandom);
      w  = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 59) == 0);
      step(r, w, rr, a, d, acc);
    end
    idle(6);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
